// File: rtl/bridge_reg_bank_pkg.sv
// Shared types and address-map helpers for the bridge register bank.
// - bridge_reg_bank_cfg_t : per-register reset value and writable-bit mask
// - reg_idx_t             : register index type (up to 16 data registers)
// - status_ofs/commit_ofs : byte offsets of STATUS and COMMIT relative to BASE_ADDR
// - masked_merge          : masked register update used by every slot
package bridge_reg_bank_pkg;

    localparam int MAX_REGS = 16;

    typedef logic [3:0] reg_idx_t;

    typedef struct packed {
        logic [31:0] reset_value;
        logic [31:0] write_mask;
    } bridge_reg_bank_cfg_t;

    // STATUS sits directly after the last data register.
    function automatic logic [31:0] status_ofs(input int num_regs);
        return 32'(4 * num_regs);
    endfunction

    // COMMIT sits directly after STATUS.
    function automatic logic [31:0] commit_ofs(input int num_regs);
        return 32'(4 * num_regs + 4);
    endfunction

    // Only bits set in mask take the new data; the rest keep their old value.
    function automatic logic [31:0] masked_merge(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/bridge_reg_bank_if.sv
// Bridge bus bundle between a bridge master and one register-bank leaf.
// master: drives bridge_addr/bridge_wr/bridge_wr_data/bridge_rd, receives read data and hit.
// slave : the opposite directions.
interface bridge_reg_bank_if;

    logic [31:0] bridge_addr;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;
    logic        bridge_rd_hit;

    modport master (
        output bridge_addr,
        output bridge_wr,
        output bridge_wr_data,
        output bridge_rd,
        input  bridge_rd_data,
        input  bridge_rd_hit
    );

    modport slave (
        input  bridge_addr,
        input  bridge_wr,
        input  bridge_wr_data,
        input  bridge_rd,
        output bridge_rd_data,
        output bridge_rd_hit
    );

endinterface

// File: rtl/bridge_reg_slot.sv
// One masked control register with shadow/live copies and change detection.
// Ports:
//   clk_74a  in   bridge clock
//   reset    in   synchronous active-high reset (live = shadow = reset value)
//   wr_en    in   write this register this cycle
//   wr_data  in   32-bit write data (masked by CFG.write_mask)
//   commit   in   copy shadow to live this cycle (COMMIT_MODE=1 only)
//   live_q   out  registered live value
//   changed  out  registered one-cycle pulse when live took a different value
module bridge_reg_slot
    import bridge_reg_bank_pkg::*;
#(
    parameter bridge_reg_bank_cfg_t CFG         = '0,
    parameter bit                   COMMIT_MODE = 1'b0
) (
    input  logic        clk_74a,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        commit,
    output logic [31:0] live_q,
    output logic        changed
);

    logic [31:0] live_r;
    logic [31:0] shadow_r;
    logic        changed_r;
    logic [31:0] live_next_s;
    logic [31:0] shadow_next_s;

    // Next-state: in commit mode writes land in shadow and commit copies the
    // pre-write shadow, so a same-cycle write is held back for the next commit.
    always_comb begin
        live_next_s   = live_r;
        shadow_next_s = shadow_r;
        if (COMMIT_MODE) begin
            if (wr_en) begin
                shadow_next_s = masked_merge(shadow_r, wr_data, CFG.write_mask);
            end else begin
                shadow_next_s = shadow_r;
            end
            if (commit) begin
                live_next_s = shadow_r;
            end else begin
                live_next_s = live_r;
            end
        end else begin
            if (wr_en) begin
                live_next_s = masked_merge(live_r, wr_data, CFG.write_mask);
            end else begin
                live_next_s = live_r;
            end
            shadow_next_s = live_next_s;
        end
    end

    // Register state; change pulse is raised together with the new live value.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            live_r    <= CFG.reset_value;
            shadow_r  <= CFG.reset_value;
            changed_r <= 1'b0;
        end else begin
            live_r    <= live_next_s;
            shadow_r  <= shadow_next_s;
            changed_r <= (live_next_s != live_r);
        end
    end

    assign live_q  = live_r;
    assign changed = changed_r;

endmodule

// File: rtl/bridge_reg_bank.sv
// Bridge-mapped control/status register bank.
// Map (byte offsets from BASE_ADDR): REG[i] at 4*i, STATUS at 4*NUM_REGS (W1C sticky),
// COMMIT at 4*NUM_REGS+4 (write = commit in COMMIT_MODE=1, read = {31'b0, pending}).
// Ports:
//   clk_74a      in   bridge clock
//   reset        in   synchronous active-high reset
//   bus          slave bridge bundle (addr/wr/wr_data/rd in, registered rd_data/rd_hit out)
//   ext_sel      in   per external source "address is mine" (index 0 has highest priority)
//   ext_rd_data  in   per external source read data
//   commit_strobe in  apply shadow to live (COMMIT_MODE=1 only)
//   regs_q       out  live register values
//   reg_changed  out  one-cycle pulse per register when its live value changes
//   status_set   in   sticky event bits OR-ed into STATUS every cycle
//   status_irq   out  registered OR-reduction of STATUS
module bridge_reg_bank
    import bridge_reg_bank_pkg::*;
#(
    parameter logic [31:0]                 BASE_ADDR    = 32'h0010_0000,
    parameter int                          NUM_REGS     = 4,
    parameter logic [NUM_REGS-1:0][31:0]   RESET_VALUES = '0,
    parameter logic [NUM_REGS-1:0][31:0]   WRITE_MASKS  = '1,
    parameter bit                          COMMIT_MODE  = 1'b0,
    parameter int                          NUM_EXT      = 1,
    localparam int                         EXT_W        = (NUM_EXT > 0) ? NUM_EXT : 1
) (
    input  logic                          clk_74a,
    input  logic                          reset,
    bridge_reg_bank_if.slave              bus,
    input  logic [EXT_W-1:0]              ext_sel,
    input  logic [EXT_W-1:0][31:0]        ext_rd_data,
    input  logic                          commit_strobe,
    output logic [NUM_REGS-1:0][31:0]     regs_q,
    output logic [NUM_REGS-1:0]           reg_changed,
    input  logic [31:0]                   status_set,
    output logic                          status_irq
);

    localparam logic [31:0] STATUS_OFS = status_ofs(NUM_REGS);
    localparam logic [31:0] COMMIT_OFS = commit_ofs(NUM_REGS);

    logic [31:0]         ofs_s;
    logic                addr_ok_s;
    logic [NUM_REGS-1:0] reg_hit_s;
    logic [NUM_REGS-1:0] reg_wr_s;
    logic                status_hit_s;
    logic                commit_hit_s;
    logic                any_reg_wr_s;
    logic                commit_s;
    logic [31:0]         status_clr_s;
    logic [31:0]         status_next_s;
    logic [31:0]         rd_data_next_s;
    logic                rd_hit_next_s;

    logic [31:0]         status_r;
    logic                status_irq_r;
    logic                pending_r;
    logic [31:0]         rd_data_r;
    logic                rd_hit_r;

    // Address decode; addresses below BASE or not word-aligned never hit.
    always_comb begin
        ofs_s        = bus.bridge_addr - BASE_ADDR;
        addr_ok_s    = (bus.bridge_addr >= BASE_ADDR) && (bus.bridge_addr[1:0] == 2'b00);
        reg_hit_s    = '0;
        reg_wr_s     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_hit_s[i] = addr_ok_s && (ofs_s == 32'(4 * i));
            reg_wr_s[i]  = bus.bridge_wr && reg_hit_s[i];
        end
        status_hit_s = addr_ok_s && (ofs_s == STATUS_OFS);
        commit_hit_s = addr_ok_s && (ofs_s == COMMIT_OFS);
        any_reg_wr_s = |reg_wr_s;
        commit_s     = COMMIT_MODE && (commit_strobe || (bus.bridge_wr && commit_hit_s));
    end

    // STATUS next value: write-one-to-clear, then set bits OR-ed in so set wins.
    always_comb begin
        if (bus.bridge_wr && status_hit_s) begin
            status_clr_s = bus.bridge_wr_data;
        end else begin
            status_clr_s = 32'h0000_0000;
        end
        status_next_s = (status_r & ~status_clr_s) | status_set;
    end

    // Read mux: internal hits first, then ext_sel[0], ext_sel[1], ...
    always_comb begin
        rd_data_next_s = 32'h0000_0000;
        rd_hit_next_s  = 1'b0;
        if (|reg_hit_s) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_hit_s[i]) begin
                    rd_data_next_s = regs_q[i];
                end else begin
                    rd_data_next_s = rd_data_next_s;
                end
            end
            rd_hit_next_s = 1'b1;
        end else if (status_hit_s) begin
            rd_data_next_s = status_r;
            rd_hit_next_s  = 1'b1;
        end else if (commit_hit_s) begin
            rd_data_next_s = {31'd0, pending_r};
            rd_hit_next_s  = 1'b1;
        end else begin
            // Walk from the lowest-priority source up so index 0 is applied last.
            for (int e = NUM_EXT - 1; e >= 0; e--) begin
                if (ext_sel[e]) begin
                    rd_data_next_s = ext_rd_data[e];
                    rd_hit_next_s  = 1'b1;
                end else begin
                    rd_data_next_s = rd_data_next_s;
                    rd_hit_next_s  = rd_hit_next_s;
                end
            end
        end
    end

    // Pending flag: a register write keeps it set even when a commit lands the same cycle.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            pending_r <= 1'b0;
        end else if (COMMIT_MODE && any_reg_wr_s) begin
            pending_r <= 1'b1;
        end else if (commit_s) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Sticky STATUS register and its registered interrupt.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            status_r     <= 32'h0000_0000;
            status_irq_r <= 1'b0;
        end else begin
            status_r     <= status_next_s;
            status_irq_r <= |status_r;
        end
    end

    // Registered read return.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            rd_data_r <= 32'h0000_0000;
            rd_hit_r  <= 1'b0;
        end else begin
            rd_data_r <= rd_data_next_s;
            rd_hit_r  <= rd_hit_next_s;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        localparam bridge_reg_bank_cfg_t SLOT_CFG = '{
            reset_value: RESET_VALUES[g],
            write_mask:  WRITE_MASKS[g]
        };

        bridge_reg_slot #(
            .CFG         (SLOT_CFG),
            .COMMIT_MODE (COMMIT_MODE)
        ) u_slot (
            .clk_74a (clk_74a),
            .reset   (reset),
            .wr_en   (reg_wr_s[g]),
            .wr_data (bus.bridge_wr_data),
            .commit  (commit_s),
            .live_q  (regs_q[g]),
            .changed (reg_changed[g])
        );
    end

    assign bus.bridge_rd_data = rd_data_r;
    assign bus.bridge_rd_hit  = rd_hit_r;
    assign status_irq         = status_irq_r;

endmodule
